score_bcd_accumulator: RTL and testbench

- Upstream of the seven-segment display controller: produces the 16-bit packed-BCD score word that feeds its `big_bin` input.
- Accepts brick-hit events, each carrying a point value, and queues them in a small FIFO.
- Adds each queued value to a 4-digit BCD score using one-digit-per-cycle serial carry.
- Commits the result atomically, so the display never sees an intermediate digit state.

---
 rtl/score_bcd_accumulator.sv | 258 +++++++++++++++++++++++++
 tb/tb_score_bcd_accumulator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_accumulator.sv
// -----------------------------------------------------------------------------
// score_bcd_accumulator
//
// Purpose:
//   Builds the 4-digit packed-BCD score word shown by the seven-segment display
//   controller. Brick-hit events (rising edges of hit_in) carry a point value,
//   which is clamped and queued in a small FIFO. A five-state FSM pops one
//   entry at a time into a working copy of the score and ripples the addition
//   through the BCD digits, one digit per cycle. Only the final result is
//   committed to big_bin, so the display never sees a half-carried value.
//
// Ports:
//   clk        in   system clock, shared with the display controller
//   rst_n      in   asynchronous active-low reset
//   hit_in     in   brick-hit level; each rising edge is one event
//   points     in   point value sampled on the hit edge (0 -> 1, >MAX -> MAX)
//   clear      in   synchronous game clear, active high, beats hits/commits
//   big_bin    out  packed BCD score, [15:12] thousands .. [3:0] ones
//   busy       out  work pending (FIFO non-empty or FSM not idle)
//   saturated  out  sticky, score has been clamped at 9999
//   dropped    out  sticky, a hit was lost because the FIFO was full
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting; pops the FIFO head and snapshots big_bin when work exists
//   S_D0   | adds the popped points to the ones digit
//   S_D1   | propagates carry into the tens digit
//   S_D2   | propagates carry into the hundreds digit
//   S_D3   | propagates carry into thousands and commits (or saturates)
// -----------------------------------------------------------------------------
module score_bcd_accumulator #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_POINTS = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit_in,
  input  logic [3:0]  points,
  input  logic        clear,
  output logic [15:0] big_bin,
  output logic        busy,
  output logic        saturated,
  output logic        dropped
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] MAX_PTS = 4'(MAX_POINTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_D0,
    S_D1,
    S_D2,
    S_D3
  } state_e;

  // Single BCD digit add: returns {carry_out, digit}. Inputs never exceed
  // 9 + 9, so one conditional subtract of 10 is enough.
  function automatic logic [4:0] digit_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    logic [4:0] sum_m10;
    sum     = {1'b0, a} + {1'b0, b};
    sum_m10 = sum - 5'd10;
    if (sum > 5'd9) begin
      digit_add = {1'b1, sum_m10[3:0]};
    end else begin
      digit_add = {1'b0, sum[3:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             state_q,   state_d;
  logic               hit_q;
  logic [3:0]         mem_q [FIFO_DEPTH];
  logic [3:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [3:0]         addend_q,  addend_d;
  logic [15:0]        work_q,    work_d;
  logic               carry_q,   carry_d;
  logic [15:0]        big_bin_q, big_bin_d;
  logic               sat_q,     sat_d;
  logic               drop_q,    drop_d;
  logic               busy_q,    busy_d;

  // ---------------------------------------------------------------------------
  // Event detect, clamp and FIFO handshake
  // ---------------------------------------------------------------------------
  logic       hit_evt;
  logic       pop;
  logic       push_ok;
  logic [3:0] pts_clamped;

  assign hit_evt = hit_in & ~hit_q;

  always_comb begin
    pts_clamped = points;
    if (points == 4'd0) begin
      pts_clamped = 4'd1;
    end else if (points > MAX_PTS) begin
      pts_clamped = MAX_PTS;
    end
  end

  // The FSM only pops from IDLE; a pop in the same cycle frees a slot, so a
  // push into a full FIFO is still accepted then.
  assign pop     = (state_q == S_IDLE) && (cnt_q != '0);
  assign push_ok = hit_evt && ((cnt_q != CNT_FULL) || pop);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [4:0] d0_res;
  logic [4:0] d1_res;
  logic [4:0] d2_res;
  logic [4:0] d3_res;

  assign d0_res = digit_add(work_q[3:0],   addend_q);
  assign d1_res = digit_add(work_q[7:4],   {3'b000, carry_q});
  assign d2_res = digit_add(work_q[11:8],  {3'b000, carry_q});
  assign d3_res = digit_add(work_q[15:12], {3'b000, carry_q});

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    addend_d  = addend_q;
    work_d    = work_q;
    carry_d   = carry_q;
    big_bin_d = big_bin_q;
    sat_d     = sat_q;
    drop_d    = drop_q;

    // FIFO
    if (push_ok) begin
      mem_d[wr_ptr_q] = pts_clamped;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (hit_evt && !push_ok) begin
      drop_d = 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Serial BCD add
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          addend_d = mem_q[rd_ptr_q];
          work_d   = big_bin_q;
          carry_d  = 1'b0;
          state_d  = S_D0;
        end
      end
      S_D0: begin
        work_d[3:0] = d0_res[3:0];
        carry_d     = d0_res[4];
        state_d     = S_D1;
      end
      S_D1: begin
        work_d[7:4] = d1_res[3:0];
        carry_d     = d1_res[4];
        state_d     = S_D2;
      end
      S_D2: begin
        work_d[11:8] = d2_res[3:0];
        carry_d      = d2_res[4];
        state_d      = S_D3;
      end
      S_D3: begin
        work_d[15:12] = d3_res[3:0];
        carry_d       = d3_res[4];
        // Carry out of thousands means the true score passed 9999.
        if (d3_res[4]) begin
          big_bin_d = 16'h9999;
          sat_d     = 1'b1;
        end else begin
          big_bin_d = {d3_res[3:0], work_q[11:0]};
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear overrides everything above, including a same-cycle event
    // (discarded without flagging dropped) and a D3 commit.
    if (clear) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      carry_d   = 1'b0;
      big_bin_d = 16'h0000;
      sat_d     = 1'b0;
      drop_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE) || (cnt_d != '0);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hit_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 4'd0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addend_q  <= 4'd0;
      work_q    <= 16'h0000;
      carry_q   <= 1'b0;
      big_bin_q <= 16'h0000;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_in;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addend_q  <= addend_d;
      work_q    <= work_d;
      carry_q   <= carry_d;
      big_bin_q <= big_bin_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  assign big_bin   = big_bin_q;
  assign busy      = busy_q;
  assign saturated = sat_q;
  assign dropped   = drop_q;

endmodule

// File: tb/tb_score_bcd_accumulator.sv
module tb_score_bcd_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit_in = 1'b0;
  logic [3:0]  points = 4'd0;
  logic        clear = 1'b0;
  logic [15:0] big_bin;
  logic        busy;
  logic        saturated;
  logic        dropped;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_score = 16'h0000;
  logic [15:0] last_seen = 16'h0000;
  logic [15:0] mon_exp;
  bit          mon_en = 1'b0;

  score_bcd_accumulator #(.FIFO_DEPTH(4), .MAX_POINTS(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_in    (hit_in),
    .points    (points),
    .clear     (clear),
    .big_bin   (big_bin),
    .busy      (busy),
    .saturated (saturated),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic, converted to/from BCD.
  function automatic int bcd_to_int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int clamp_pts(input logic [3:0] p);
    if (p == 4'd0) return 1;
    if (p > 4'd9) return 9;
    return int'(p);
  endfunction

  task automatic expect_commit(input logic [3:0] p);
    int s;
    s = bcd_to_int(model_score) + clamp_pts(p);
    if (s > 9999) s = 9999;
    if (int_to_bcd(s) != model_score) exp_q.push_back(int_to_bcd(s));
    model_score = int_to_bcd(s);
  endtask

  task automatic expect_zero();
    if (model_score != 16'h0000) exp_q.push_back(16'h0000);
    model_score = 16'h0000;
  endtask

  // Scoreboard: every visible change of big_bin must be the next expected
  // committed score; anything else (e.g. a half-carried value) is flagged.
  always @(negedge clk) begin
    if (mon_en && (big_bin !== last_seen)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected: big_bin=%h, required unchanged %h", big_bin, last_seen);
      end else begin
        mon_exp = exp_q.pop_front();
        if (big_bin !== mon_exp) $display("FAIL scoreboard_value: big_bin=%h, required %h", big_bin, mon_exp);
        else n_pass++;
      end
      last_seen = big_bin;
    end
  end

  // All tasks start and end at #1 after a rising clock edge.
  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL wait_idle_%s: busy=%b after %0d cycles, required 0", tag, busy, cyc);
    else n_pass++;
  endtask

  task automatic check_q_empty(input string tag);
    @(posedge clk); #1;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL pending_%s: %0d expected scores never seen, required 0", tag, exp_q.size());
    else n_pass++;
  endtask

  task automatic do_hit(input logic [3:0] p);
    hit_in = 1'b1;
    points = p;
    expect_commit(p);
    @(posedge clk); #1;
    hit_in = 1'b0;
    wait_idle("hit");
  endtask

  task automatic pulse(input logic [3:0] p);
    hit_in = 1'b1;
    points = p;
    @(posedge clk); #1;
    hit_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    expect_zero();
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    n_total++; if (big_bin !== 16'h0000) $display("FAIL reset_big_bin: got %h, required 0000", big_bin); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (saturated !== 1'b0) $display("FAIL reset_saturated: got %b, required 0", saturated); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL reset_dropped: got %b, required 0", dropped); else n_pass++;
  endtask

  task automatic test_latency();
    hit_in = 1'b1;
    points = 4'd5;
    expect_commit(4'd5);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) hit_in = 1'b0;
      n_total++;
      if (busy !== (k <= 5)) $display("FAIL latency_busy_e%0d: got %b, required %b", k, busy, (k <= 5));
      else n_pass++;
      n_total++;
      if (big_bin !== ((k < 6) ? 16'h0000 : 16'h0005)) $display("FAIL latency_big_bin_e%0d: got %h, required %h", k, big_bin, ((k < 6) ? 16'h0000 : 16'h0005));
      else n_pass++;
    end
    check_q_empty("latency");
  endtask

  task automatic test_carry_chain();
    do_clear();
    for (int i = 0; i < 11; i++) do_hit(4'd9);
    n_total++; if (big_bin !== 16'h0099) $display("FAIL carry_preload: got %h, required 0099", big_bin); else n_pass++;
    do_hit(4'd3);
    n_total++; if (big_bin !== 16'h0102) $display("FAIL carry_0102: got %h, required 0102", big_bin); else n_pass++;
    check_q_empty("carry");
  endtask

  task automatic test_back_to_back();
    do_clear();
    // Events land on edges 1,3,5,7,9; the FSM pops on edges 2 and 7, so at
    // most three entries wait and nothing is lost.
    for (int i = 0; i < 5; i++) begin
      expect_commit(4'd9);
      pulse(4'd9);
    end
    wait_idle("b2b");
    n_total++; if (big_bin !== 16'h0045) $display("FAIL b2b_score: got %h, required 0045", big_bin); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL b2b_dropped: got %b, required 0", dropped); else n_pass++;
    check_q_empty("b2b");
  endtask

  task automatic test_clamp_hold();
    do_clear();
    hit_in = 1'b1;
    points = 4'd2;
    expect_commit(4'd2);
    repeat (20) begin @(posedge clk); #1; end
    hit_in = 1'b0;
    wait_idle("hold");
    n_total++; if (big_bin !== 16'h0002) $display("FAIL hold_single_add: got %h, required 0002", big_bin); else n_pass++;
    do_hit(4'd0);
    n_total++; if (big_bin !== 16'h0003) $display("FAIL clamp_zero: got %h, required 0003", big_bin); else n_pass++;
    do_hit(4'd15);
    n_total++; if (big_bin !== 16'h0012) $display("FAIL clamp_fifteen: got %h, required 0012", big_bin); else n_pass++;
    check_q_empty("clamp");
  endtask

  task automatic test_fifo_overflow();
    do_clear();
    // Nine pulses two cycles apart, points 1..9. Pops happen on edges
    // 2,7,12,17; the FIFO is full with no pop at the 8th event (edge 15) so
    // it is lost, while the 9th (edge 17) coincides with a pop and is kept.
    for (int i = 1; i <= 9; i++) begin
      if (i != 8) expect_commit(4'(i));
      pulse(4'(i));
      if (i == 7) begin
        n_total++; if (dropped !== 1'b0) $display("FAIL ovf_dropped_early: got %b, required 0", dropped); else n_pass++;
      end
      if (i == 8) begin
        n_total++; if (dropped !== 1'b1) $display("FAIL ovf_dropped_set: got %b, required 1", dropped); else n_pass++;
      end
    end
    wait_idle("ovf");
    n_total++; if (big_bin !== 16'h0037) $display("FAIL ovf_score: got %h, required 0037", big_bin); else n_pass++;
    n_total++; if (dropped !== 1'b1) $display("FAIL ovf_dropped_sticky: got %b, required 1", dropped); else n_pass++;
    check_q_empty("ovf");
  endtask

  task automatic test_clear_mid_add();
    hit_in = 1'b1;
    points = 4'd4;
    @(posedge clk); #1;   // edge 1: push
    hit_in = 1'b0;
    @(posedge clk); #1;   // edge 2: pop, D0
    @(posedge clk); #1;   // edge 3: now in D1
    clear = 1'b1;
    hit_in = 1'b1;
    points = 4'd6;
    expect_zero();
    @(posedge clk); #1;
    clear = 1'b0;
    n_total++; if (big_bin !== 16'h0000) $display("FAIL clr_big_bin: got %h, required 0000", big_bin); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL clr_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL clr_dropped: got %b, required 0", dropped); else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    hit_in = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    n_total++; if (big_bin !== 16'h0000) $display("FAIL clr_stays_zero: got %h, required 0000", big_bin); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL clr_stays_idle: got %b, required 0", busy); else n_pass++;
    check_q_empty("clr");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 1110; i++) do_hit(4'd9);
    do_hit(4'd5);
    n_total++; if (big_bin !== 16'h9995) $display("FAIL sat_preload: got %h, required 9995", big_bin); else n_pass++;
    n_total++; if (saturated !== 1'b0) $display("FAIL sat_not_yet: got %b, required 0", saturated); else n_pass++;
    do_hit(4'd7);
    n_total++; if (big_bin !== 16'h9999) $display("FAIL sat_clamp: got %h, required 9999", big_bin); else n_pass++;
    n_total++; if (saturated !== 1'b1) $display("FAIL sat_flag: got %b, required 1", saturated); else n_pass++;
    do_hit(4'd1);
    n_total++; if (big_bin !== 16'h9999) $display("FAIL sat_hold: got %h, required 9999", big_bin); else n_pass++;
    n_total++; if (saturated !== 1'b1) $display("FAIL sat_sticky: got %b, required 1", saturated); else n_pass++;
    check_q_empty("sat");
  endtask

  task automatic test_async_reset();
    hit_in = 1'b1;
    points = 4'd3;
    expect_commit(4'd3);
    @(posedge clk); #1;
    hit_in = 1'b0;
    @(posedge clk); #2;   // mid-cycle, add in progress
    rst_n = 1'b0;
    expect_zero();
    #1;
    n_total++; if (big_bin !== 16'h0000) $display("FAIL arst_big_bin: got %h, required 0000", big_bin); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b, required 0", busy); else n_pass++;
    n_total++; if (saturated !== 1'b0) $display("FAIL arst_saturated: got %b, required 0", saturated); else n_pass++;
    n_total++; if (dropped !== 1'b0) $display("FAIL arst_dropped: got %b, required 0", dropped); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    n_total++; if (big_bin !== 16'h0000) $display("FAIL arst_after: got %h, required 0000", big_bin); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_idle: got %b, required 0", busy); else n_pass++;
    check_q_empty("arst");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_carry_chain();
    test_back_to_back();
    test_clamp_hold();
    test_fifo_overflow();
    test_clear_mid_add();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
